// File: rtl/ex_pkg.sv
// Shared execute-stage types for the multi-cycle divider: op encodings,
// sequencer states and the iteration count.
package ex_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_CALC  = 2'b01,
    S_FIXUP = 2'b10,
    S_DONE  = 2'b11
  } div_state_e;

  localparam int DIV_ITERATIONS = 32;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit and
// subtract the divisor if the partial remainder is large enough.
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN:0]   rem_i,
  input  logic            dvd_msb_i,
  input  logic [XLEN-1:0] dvs_i,
  output logic [XLEN:0]   rem_o,
  output logic            q_bit_o
);

  // One spare bit above the 33-bit remainder carries the trial sign.
  logic [XLEN+1:0] shifted;
  logic [XLEN+1:0] trial;

  assign shifted = {rem_i, dvd_msb_i};
  assign trial   = shifted - {2'b00, dvs_i};
  assign q_bit_o = ~trial[XLEN+1];
  assign rem_o   = q_bit_o ? trial[XLEN:0] : shifted[XLEN:0];

endmodule

// File: rtl/ex_div_sequencer.sv
// RV32M divide/remainder sequencer: radix-2 restoring divider that stalls EX
// for 34 cycles (or 1 cycle for divide-by-zero / signed overflow).
module ex_div_sequencer
  import ex_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [4:0]      rd_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_o
);

  localparam int CW = $clog2(DIV_ITERATIONS);
  localparam logic [CW-1:0] LAST_ITER = CW'(DIV_ITERATIONS - 1);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN:0]   rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;   // dividend shifts out as quotient shifts in
  logic [XLEN-1:0] dvs_q, dvs_d;
  div_op_e         op_q, op_d;
  logic [4:0]      rd_q, rd_d;
  logic            qsign_q, qsign_d;
  logic            rsign_q, rsign_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [4:0]      rdo_q, rdo_d;

  logic [XLEN:0]   step_rem;
  logic            step_q;

  div_step #(.XLEN(XLEN)) u_step (
    .rem_i     (rem_q),
    .dvd_msb_i (quo_q[XLEN-1]),
    .dvs_i     (dvs_q),
    .rem_o     (step_rem),
    .q_bit_o   (step_q)
  );

  logic            can_accept, accept;
  logic            is_signed, a_neg, b_neg, div0, ovf;
  logic [XLEN-1:0] a_abs, b_abs, q_fix, r_fix;

  assign is_signed  = ~op_i[0];
  assign a_neg      = is_signed & rs1_data_i[XLEN-1];
  assign b_neg      = is_signed & rs2_data_i[XLEN-1];
  assign a_abs      = a_neg ? (~rs1_data_i + 1'b1) : rs1_data_i;
  assign b_abs      = b_neg ? (~rs2_data_i + 1'b1) : rs2_data_i;
  assign div0       = (rs2_data_i == '0);
  assign ovf        = is_signed & (rs1_data_i == INT_MIN) & (&rs2_data_i);
  assign can_accept = (state_q == S_IDLE) | (state_q == S_DONE);
  assign accept     = can_accept & start_i & ~flush_i;

  assign q_fix = ((op_q == OP_DIV) && qsign_q) ? (~quo_q + 1'b1) : quo_q;
  assign r_fix = ((op_q == OP_REM) && rsign_q) ? (~rem_q[XLEN-1:0] + 1'b1)
                                                : rem_q[XLEN-1:0];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    op_d     = op_q;
    rd_d     = rd_q;
    qsign_d  = qsign_q;
    rsign_d  = rsign_q;
    result_d = result_q;
    rdo_d    = rdo_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (accept) begin
          if (div0 || ovf) begin
            // Architecturally defined results bypass the iteration loop.
            if (op_i[1]) result_d = div0 ? rs1_data_i : '0;
            else         result_d = div0 ? '1 : INT_MIN;
            rdo_d   = rd_i;
            state_d = S_DONE;
          end else begin
            quo_d   = a_abs;
            dvs_d   = b_abs;
            op_d    = div_op_e'(op_i);
            rd_d    = rd_i;
            qsign_d = a_neg ^ b_neg;
            rsign_d = a_neg;
            rem_d   = '0;
            cnt_d   = '0;
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        rem_d = step_rem;
        quo_d = {quo_q[XLEN-2:0], step_q};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) state_d = S_FIXUP;
      end
      S_FIXUP: begin
        result_d = op_q[1] ? r_fix : q_fix;
        rdo_d    = rd_q;
        state_d  = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush_i) state_d = S_IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      op_q     <= OP_DIV;
      rd_q     <= '0;
      qsign_q  <= 1'b0;
      rsign_q  <= 1'b0;
      result_q <= '0;
      rdo_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      qsign_q  <= qsign_d;
      rsign_q  <= rsign_d;
      result_q <= result_d;
      rdo_q    <= rdo_d;
    end
  end

  assign busy_o   = (state_q == S_CALC) | (state_q == S_FIXUP);
  assign valid_o  = (state_q == S_DONE);
  assign stall_o  = busy_o | accept;
  assign result_o = result_q;
  assign rd_o     = rdo_q;

endmodule

// File: tb/tb_ex_div_sequencer.sv
// Randomized + directed bench for ex_div_sequencer against an arithmetic
// reference of RV32M division semantics.
module tb_ex_div_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs1, rs2;
  logic [4:0]  rd;
  logic        flush;
  logic        stall, busy, valid;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ex_div_sequencer dut (
    .clk_i      (clk),
    .reset_i    (reset_n),
    .start_i    (start),
    .op_i       (op),
    .rs1_data_i (rs1),
    .rs2_data_i (rs2),
    .rd_i       (rd),
    .flush_i    (flush),
    .stall_o    (stall),
    .busy_o     (busy),
    .valid_o    (valid),
    .result_o   (result),
    .rd_o       (rd_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit is_special(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    return (b == 0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    if (b == 0) return o[1] ? a : 32'hFFFF_FFFF;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return o[1] ? 32'h0 : 32'h8000_0000;
    case (o)
      2'b00:   return sa / sb;
      2'b01:   return a / b;
      2'b10:   return sa % sb;
      default: return a % b;
    endcase
  endfunction

  // Called on a negedge: present a new instruction in EX.
  task automatic drive(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic [4:0] r);
    start = 1'b1; op = o; rs1 = a; rs2 = b; rd = r;
  endtask

  // Track one accepted op from cycle 0 to its valid cycle. With chain set, the
  // next instruction is presented in the valid cycle (back-to-back accept).
  task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] r, input bit chain, input logic [1:0] o2,
                     input logic [31:0] a2, input logic [31:0] b2, input logic [4:0] r2);
    int lat, serr;
    logic [31:0] exp;
    lat  = is_special(o, a, b) ? 1 : 34;
    exp  = ref_div(o, a, b);
    serr = 0;
    #1;
    if (stall !== 1'b1) serr++;
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      if (c < lat) start = 1'b1;
      else if (chain) drive(o2, a2, b2, r2);
      else start = 1'b0;
      #1;
      if (stall !== ((c < lat) || (c == lat && chain))) serr++;
      if (busy !== (c < lat)) serr++;
      if (c < lat && valid !== 1'b0) serr++;
    end
    check("stall_busy_seq", serr, 0);
    check("valid", {31'b0, valid}, 32'h1);
    check("result", result, exp);
    check("rd", {27'b0, rd_out}, {27'b0, r});
  endtask

  task automatic run1(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic [4:0] r);
    @(negedge clk);
    drive(o, a, b, r);
    run(o, a, b, r, 1'b0, 2'b0, 32'h0, 32'h0, 5'd0);
  endtask

  initial begin
    int verr;
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    logic [4:0]  rr;
    reset_n = 1'b0; start = 1'b0; flush = 1'b0;
    op = 2'b0; rs1 = '0; rs2 = '0; rd = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_valid", {31'b0, valid}, 0);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_result", result, 0);
    check("rst_rd", {27'b0, rd_out}, 0);
    reset_n = 1'b1;

    // Directed cases
    run1(2'b01, 32'd100, 32'd7, 5'd5);
    run1(2'b11, 32'd100, 32'd7, 5'd6);
    run1(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd7);
    run1(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd8);
    run1(2'b00, 32'd7, 32'hFFFF_FFFE, 5'd9);
    run1(2'b10, 32'd7, 32'hFFFF_FFFE, 5'd10);
    run1(2'b01, 32'd5, 32'd0, 5'd11);
    run1(2'b11, 32'd5, 32'd0, 5'd12);
    run1(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13);
    run1(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14);
    run1(2'b01, 32'hFFFF_FFFF, 32'd1, 5'd15);

    // Flush in cycle 10 of a DIVU
    @(negedge clk);
    drive(2'b01, 32'd1000, 32'd10, 5'd3);
    verr = 0;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      start = (c <= 10);
      flush = (c == 10);
      #1;
      if (valid !== 1'b0) verr++;
    end
    flush = 1'b0;
    check("flush_no_valid", verr, 0);
    check("flush_stall", {31'b0, stall}, 0);
    check("flush_busy", {31'b0, busy}, 0);
    @(negedge clk);
    drive(2'b01, 32'd1000, 32'd10, 5'd4);
    run(2'b01, 32'd1000, 32'd10, 5'd4, 1'b0, 2'b0, 32'h0, 32'h0, 5'd0);

    // Reset in cycle 15 of a DIV
    @(negedge clk);
    drive(2'b00, 32'hFFFF_0000, 32'd3, 5'd21);
    verr = 0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      start   = (c <= 15);
      reset_n = (c != 15);
      #1;
      if (c < 15 && (valid !== 1'b0 || busy !== 1'b1)) verr++;
    end
    check("pre_reset_seq", verr, 0);
    check("rreset_valid", {31'b0, valid}, 0);
    check("rreset_busy", {31'b0, busy}, 0);
    check("rreset_stall", {31'b0, stall}, 0);
    check("rreset_result", result, 0);
    check("rreset_rd", {27'b0, rd_out}, 0);

    // Back-to-back: second start in the DONE cycle of a DIVU
    @(negedge clk);
    drive(2'b01, 32'd123456, 32'd789, 5'd17);
    run(2'b01, 32'd123456, 32'd789, 5'd17, 1'b1, 2'b11, 32'd99999, 32'd13, 5'd18);
    run(2'b11, 32'd99999, 32'd13, 5'd18, 1'b0, 2'b0, 32'h0, 32'h0, 5'd0);

    // start and flush together in IDLE: nothing accepted
    @(negedge clk);
    drive(2'b01, 32'd50, 32'd5, 5'd2);
    flush = 1'b1;
    #1;
    check("sf_stall", {31'b0, stall}, 0);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    #1;
    check("sf_busy", {31'b0, busy}, 0);
    check("sf_valid", {31'b0, valid}, 0);

    // Randomized ops, biased toward corner operands
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'h0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 20));
        3: rb = -32'($urandom_range(1, 20));
        4: ra = 32'($urandom_range(0, 100));
        default: ;
      endcase
      rr = 5'($urandom);
      run1(ro, ra, rb, rr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ex_div_sequencer.md
# ex_div_sequencer

Multi-cycle controller that sequences RV32M division (DIV, DIVU, REM, REMU) on behalf of the execute stage. It captures operands when EX issues a divide and runs a radix-2 restoring divider for 32 iterations. It holds EX stalled until the result is ready, then presents the result with its destination register for one cycle. It sits beside the single-cycle ALU in EX; the EX output mux selects its result when `valid_o` is high.

## Interface
- `XLEN`, 32, operand/result width; only 32 is supported.
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `reset_i`  in  1  synchronous, active-low reset; sampled on the rising edge of `clk_i`.
- `start_i`  in  1  EX has a divide-class instruction; qualified by state.
- `op_i`  in  2  operation select: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- `rs1_data_i`  in  XLEN  dividend.
- `rs2_data_i`  in  XLEN  divisor.
- `rd_i`  in  5  destination register address.
- `flush_i`  in  1  pipeline flush; aborts any operation in progress.
- `stall_o`  out  1  hold IF/ID/EX pipeline registers.
- `busy_o`  out  1  state is CALC or FIXUP.
- `valid_o`  out  1  `result_o`/`rd_o` are valid this cycle (single-cycle pulse).
- `result_o`  out  XLEN  quotient or remainder.
- `rd_o`  out  5  destination register for `result_o`.

## Operation
- **States:** IDLE, CALC, FIXUP, DONE.
- **IDLE → CALC:** `start_i` and the operands form a normal case. On that edge:
  - latch the absolute values of the operands (signed ops only), `op_i`, `rd_i`, quotient sign (sign(a) XOR sign(b)) and remainder sign (sign(a));
  - clear the 33-bit partial remainder and the 5-bit counter.
- **IDLE → DONE:** `start_i` with a special case. The result is loaded directly:
  - Divide by zero: quotient 0xFFFFFFFF (all ops); remainder = dividend.
  - Signed overflow (DIV/REM, 0x80000000 / 0xFFFFFFFF): quotient 0x80000000, remainder 0.
- **CALC iteration (one per cycle):**
  - shift {rem, dividend} left by 1;
  - trial = rem − divisor (33-bit);
  - if trial is non-negative: rem = trial and quotient bit = 1; otherwise quotient bit = 0;
  - counter increments; after the iteration with counter==31, go to FIXUP.
- **FIXUP:**
  - negate the quotient if DIV and quotient sign is set;
  - negate the remainder if REM and remainder sign is set;
  - register `result_o` and `rd_o`; go to DONE.
- **DONE:**
  - `valid_o`=1 for exactly this cycle;
  - next state is IDLE, or CALC/DONE if `start_i` is high (back-to-back accept).
- **Starts ignored:** `start_i` in CALC or FIXUP is ignored. EX is stalled, so it stays asserted for the same instruction.
- **Flush:**
  - `flush_i` in any state → IDLE on the next edge; `valid_o` is suppressed.
  - `flush_i` has priority over `start_i`; no start is accepted in the flush cycle.
- **Reset:** when `reset_i`==0 at an edge, the state goes to IDLE and these are cleared: `valid_o`, `busy_o`, `result_o`, `rd_o`, counter, and all operand and remainder registers. Reset has priority over flush and start, including mid-CALC.
- **`stall_o`** (combinational) = (state is CALC or FIXUP) OR (state is IDLE or DONE, and `start_i`, and not `flush_i`). It is 0 in DONE when no new start is present.
- **Width rules:**
  - Negation is two's complement modulo 2^32.
  - The partial remainder is 33 bits so the trial sign bit is available.
  - Unsigned ops use the raw operands.

## Timing
- Define cycle 0 as the cycle in which `start_i` is accepted.
- **Normal case:**
  - CALC occupies cycles 1–32, FIXUP is cycle 33, and `valid_o` is high in cycle 34.
  - `stall_o` is high in cycles 0–33 and low in cycle 34.
- **Special case:**
  - `valid_o` is high in cycle 1; `stall_o` is high in cycle 0 only.
- `busy_o` is registered state decode with no combinational input path.
- `result_o` and `rd_o` hold their last values after DONE until the next load.
- Back-to-back: a start in the DONE cycle makes that cycle the new cycle 0.

## Structure
- Shared package `ex_pkg` contains:
  - `div_op_e` (DIV, DIVU, REM, REMU encodings);
  - `div_state_e`;
  - constant `DIV_ITERATIONS` = 32.
- Sub-module `div_step`: purely combinational single restoring iteration.
  - inputs: 33-bit rem, dividend MSB, 32-bit divisor;
  - outputs: next rem, quotient bit.
- The FSM, counter, operand registers and sign fix-up stay in `ex_div_sequencer`.

## Test plan
- DIVU 100 / 7, rd=5 → `stall_o` high cycles 0–33; cycle 34: `valid_o`=1, `result_o`=14, `rd_o`=5; REMU same operands → 2.
- DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD; REM → 0xFFFFFFFF; DIV 7 / 0xFFFFFFFE → 0xFFFFFFFD; REM → 1.
- DIVU 5 / 0 → 0xFFFFFFFF in cycle 1; REMU 5 / 0 → 5; DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0; `stall_o` only in cycle 0.
- Start DIVU 1000 / 10, `flush_i` in cycle 10 → state IDLE in cycle 11, `stall_o`/`busy_o`=0, no `valid_o`; new start in cycle 12 completes normally.
- `reset_i`=0 in cycle 15 of a DIV → all outputs 0 at the next edge and no `valid_o`; `start_i` held through CALC is not re-accepted.
- Back-to-back: second start in the DONE cycle of a DIVU → second `valid_o` exactly 34 cycles after the first; `start_i` and `flush_i` together in IDLE → no accept.
